lab_probe_hub: RTL
==================

LAB_PROBE_HUB -- requirements
Module: lab_probe_hub

Interface
REQ-001 Parameter NCH, default 4: number of probed DUT channels, legal range 2..16.
REQ-002 Parameter DW, default 16: channel and display data width, legal range 8..32.
REQ-003 Parameter SCAN_DIV, default 20000000: auto-scan dwell in lab_clk cycles (1 s at 20 MHz), minimum 2.
REQ-004 Derived CW = clog2(NCH), minimum 1: channel index width.
REQ-005 lab_clk  in  1  single clock (20 MHz); all logic on its rising edge.
REQ-006 lab_reset  in  1  reset, asynchronous assert, active-low; deassertion is synchronised internally to lab_clk.
REQ-007 step_in  in  1  raw manual step signal, asynchronous to lab_clk, treated as data.
REQ-008 ch_data  in  NCH*DW  DUT outputs, channel i at bits [i*DW +: DW].
REQ-009 mode  in  2  display mode: 00 live, 01 step-snapshot, 10 auto-scan, 11 freeze.
REQ-010 sel_ch  in  CW  channel selected for display in modes 00 and 01.
REQ-011 cap_req  in  1  manual snapshot request, level; acted on at its rising edge.
REQ-012 step_pulse  out  1  one-cycle synchronised step strobe, used as the DUT clock enable.
REQ-013 disp_data  out  DW  registered display value.
REQ-014 disp_ch  out  CW  channel index currently shown.
REQ-015 sel_err  out  1  high while the effective channel index is >= NCH.
REQ-016 step_count  out  32  number of step_pulse strobes since reset.

Function
REQ-017 step_in SHALL pass a 2-flop synchroniser, then a rising-edge detector; step_pulse is high exactly 1 cycle, 3 cycles after step_in rises; step_in held high SHALL produce no further pulses.
REQ-018 step_count SHALL increment by 1 on each step_pulse and wrap from 0xFFFFFFFF to 0.
REQ-019 The snapshot bank SHALL hold NCH registers of DW bits each; all channels are captured together from ch_data in one cycle.
REQ-020 Capture SHALL occur on step_pulse when mode=01, or on the cap_req rising edge in any mode; cap_req SHALL be edge-detected without a synchroniser.
REQ-021 A step_pulse and a cap_req edge in the same cycle SHALL cause a single capture.
REQ-022 Mode 00: disp_data <= ch_data[sel_ch] and disp_ch <= sel_ch, updated every cycle with 1-cycle latency.
REQ-023 Mode 01: disp_data <= snap[sel_ch], 1-cycle latency; the value captured in cycle t is visible at t+2.
REQ-024 Mode 10: a dwell counter runs 0..SCAN_DIV-1; at terminal count the scan index advances i -> (i+1) mod NCH; disp_data <= snap[scan index] and disp_ch <= scan index.
REQ-025 Entering mode 10 from any other mode SHALL clear the dwell counter and the scan index to 0 in that cycle.
REQ-026 Mode 11: disp_data and disp_ch SHALL hold their last values; capture per REQ-020 SHALL still update snap.
REQ-027 If the effective index is >= NCH (possible when NCH is not a power of 2), disp_data <= 0, disp_ch <= index, and sel_err = 1; otherwise sel_err = 0. In mode 11, sel_err holds.
REQ-028 A mode change SHALL take effect on the next clock; there SHALL be no blanking cycle.

Reset
REQ-029 While lab_reset=0: step_pulse=0, disp_data=0, disp_ch=0, sel_err=0, step_count=0; all snap registers, synchroniser flops, edge-detect flops, dwell counter and scan index are 0.
REQ-030 Reset asserted mid-scan or mid-capture SHALL abort immediately with no partial update.
REQ-031 The first step_pulse SHALL require a step_in rising edge after lab_reset is released; a step_in already high at release SHALL not pulse.

Verification
REQ-032 NCH=4, mode 00, ch1=0x1234, sel_ch=1 -> disp_data=0x1234 and disp_ch=1 one cycle later; change ch1 to 0xBEEF -> disp_data follows 1 cycle later.
REQ-033 step_in rises once and is held high 100 cycles -> step_pulse is high exactly once, 3 cycles after the rise; step_count=1.
REQ-034 Mode 01, ch[0..3]=0x11,0x22,0x33,0x44, then step; afterwards change ch_data -> sel_ch=0..3 each shows 0x11..0x44 unchanged.
REQ-035 SCAN_DIV=4, mode 10 entered at cycle 0 -> disp_ch sequence 0,1,2,3,0 with advances every 4 cycles; leave mode 10 and re-enter -> restarts at 0.
REQ-036 NCH=3, sel_ch=3 -> disp_data=0, sel_err=1; then sel_ch=2 -> sel_err=0.
REQ-037 step_count preloaded via 0xFFFFFFFF strobes (or forced), one further step -> 0; reset asserted mid-sequence -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/lab_probe_hub.sv
// lab_probe_hub: bench-side probe hub for a DUT. It synchronises a manual step
// button into a single-cycle clock-enable strobe and counts those strobes. It
// also snapshots all probed channels together and drives a registered display
// in one of four modes: live, step-snapshot, auto-scan or freeze.
module lab_probe_hub #(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int SCAN_DIV = 20000000,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              lab_clk,
    input  logic              lab_reset,
    input  logic              step_in,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     sel_ch,
    input  logic              cap_req,
    output logic              step_pulse,
    output logic [DW-1:0]     disp_data,
    output logic [CW-1:0]     disp_ch,
    output logic              sel_err,
    output logic [31:0]       step_count
);

    localparam int DCW = $clog2(SCAN_DIV);

    localparam logic [1:0] MODE_LIVE   = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    // ------------------------------------------------------------------
    // Reset: asserts at once, releases two clocks after lab_reset rises
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    // Reset release synchroniser; the flops clear asynchronously
    always_ff @(posedge lab_clk or negedge lab_reset) begin
        if (!lab_reset) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    // ------------------------------------------------------------------
    // Step input: 2-flop synchroniser, edge detect, strobe and counter
    // ------------------------------------------------------------------
    logic        step_s1_reg;
    logic        step_s2_reg;
    logic        step_s3_reg;
    logic        fill_reg;
    logic        armed_reg;
    logic        step_pulse_reg;
    logic [31:0] step_count_reg;
    logic        step_rise;

    // armed_reg is set only after step_s1_reg has sampled a real low
    // following reset, so a button already held down at release is ignored.
    assign step_rise = step_s2_reg & ~step_s3_reg & armed_reg;

    // Synchroniser, arming and one-cycle strobe generation
    always_ff @(posedge lab_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1_reg    <= 1'b0;
            step_s2_reg    <= 1'b0;
            step_s3_reg    <= 1'b0;
            fill_reg       <= 1'b0;
            armed_reg      <= 1'b0;
            step_pulse_reg <= 1'b0;
        end else begin
            step_s1_reg    <= step_in;
            step_s2_reg    <= step_s1_reg;
            step_s3_reg    <= step_s2_reg;
            fill_reg       <= 1'b1;
            armed_reg      <= armed_reg | (fill_reg & ~step_s1_reg);
            step_pulse_reg <= step_rise;
        end
    end

    // Strobe counter; advances on the same edge that raises step_pulse
    always_ff @(posedge lab_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_count_reg <= 32'd0;
        end else if (step_rise) begin
            step_count_reg <= step_count_reg + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot bank
    // ------------------------------------------------------------------
    logic          cap_d_reg;
    logic          capture;
    logic [DW-1:0] live_arr [NCH];
    logic [DW-1:0] snap_reg [NCH];

    // A step strobe and a cap_req edge in the same cycle are OR-ed: one capture.
    assign capture = (cap_req & ~cap_d_reg) | (step_pulse_reg & (mode == MODE_STEP));

    for (genvar gi = 0; gi < NCH; gi++) begin : g_live
        assign live_arr[gi] = ch_data[gi*DW +: DW];
    end

    // cap_req edge detector and parallel capture of every channel
    always_ff @(posedge lab_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_d_reg <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            cap_d_reg <= cap_req;
            if (capture) begin
                for (int i = 0; i < NCH; i++) begin
                    snap_reg[i] <= live_arr[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-scan dwell counter and scan index
    // ------------------------------------------------------------------
    logic [1:0]     mode_prev_reg;
    logic [DCW-1:0] dwell_reg;
    logic [DCW-1:0] dwell_next;
    logic [CW-1:0]  scan_reg;
    logic [CW-1:0]  scan_next;
    logic [CW-1:0]  eff_idx;
    logic           idx_bad;
    logic [DW-1:0]  live_val;
    logic [DW-1:0]  snap_val;

    // Next scan state; the display follows the next index so every channel
    // gets exactly SCAN_DIV cycles on screen, including the first one.
    always_comb begin
        dwell_next = dwell_reg;
        scan_next  = scan_reg;
        if (mode == MODE_SCAN) begin
            if (mode_prev_reg != MODE_SCAN) begin
                dwell_next = '0;
                scan_next  = '0;
            end else if (dwell_reg == DCW'(SCAN_DIV - 1)) begin
                dwell_next = '0;
                scan_next  = (scan_reg == CW'(NCH - 1)) ? '0 : scan_reg + 1'b1;
            end else begin
                dwell_next = dwell_reg + 1'b1;
            end
        end
    end

    // Effective channel index, range check and channel read muxes
    always_comb begin
        eff_idx  = (mode == MODE_SCAN) ? scan_next : sel_ch;
        idx_bad  = ({1'b0, eff_idx} >= (CW + 1)'(NCH));
        live_val = '0;
        snap_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (eff_idx == CW'(i)) begin
                live_val = live_arr[i];
                snap_val = snap_reg[i];
            end
        end
    end

    // Scan state registers and previous-mode tracker for entry detection
    always_ff @(posedge lab_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_prev_reg <= MODE_LIVE;
            dwell_reg     <= '0;
            scan_reg      <= '0;
        end else begin
            mode_prev_reg <= mode;
            dwell_reg     <= dwell_next;
            scan_reg      <= scan_next;
        end
    end

    // ------------------------------------------------------------------
    // Display registers
    // ------------------------------------------------------------------
    logic [DW-1:0] disp_data_reg;
    logic [CW-1:0] disp_ch_reg;
    logic          sel_err_reg;

    // Display update; freeze holds everything, out-of-range shows zero
    always_ff @(posedge lab_clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data_reg <= '0;
            disp_ch_reg   <= '0;
            sel_err_reg   <= 1'b0;
        end else if (mode != MODE_FREEZE) begin
            disp_ch_reg <= eff_idx;
            sel_err_reg <= idx_bad;
            if (idx_bad) begin
                disp_data_reg <= '0;
            end else if (mode == MODE_LIVE) begin
                disp_data_reg <= live_val;
            end else begin
                disp_data_reg <= snap_val;
            end
        end
    end

    assign step_pulse = step_pulse_reg;
    assign step_count = step_count_reg;
    assign disp_data  = disp_data_reg;
    assign disp_ch    = disp_ch_reg;
    assign sel_err    = sel_err_reg;

endmodule
